// File: rtl/pie_pkg.sv
// Shared types for the PIE forward-link frame sequencer: FSM states and error cause codes.
package pie_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DELIM,
    DATA0,
    RTCAL,
    FIRST,
    DATA,
    HOLD
  } pie_state_t;

  localparam logic [1:0] ERR_DELIM = 2'd0;
  localparam logic [1:0] ERR_RTCAL = 2'd1;
  localparam logic [1:0] ERR_SYM   = 2'd2;
  localparam logic [1:0] ERR_OVF   = 2'd3;

endpackage

// File: rtl/pie_edge_sync.sv
// PIE line synchronizer with registered rise/fall pulses; 3 cycles latency (4 with PIE_GLITCH_FILTER_EN).
// No backpressure: one pulse per synchronized edge; the optional majority filter rejects 1-cycle pulses.
module pie_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic in_pie,
  output logic rise,
  output logic fall
);

  logic s1, s2, line, line_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= in_pie;
      s2 <= s1;
    end
  end

`ifdef PIE_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       filt;

  // 2-of-3 vote over the current and two previous synchronized samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= 2'b11;
      filt <= 1'b1;
    end else begin
      hist <= {hist[0], s2};
      filt <= (s2 & hist[0]) | (s2 & hist[1]) | (hist[0] & hist[1]);
    end
  end

  assign line = filt;
`else
  assign line = s2;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_d <= 1'b1;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      line_d <= line;
      rise   <= line & ~line_d;
      fall   <= ~line & line_d;
    end
  end

endmodule

// File: rtl/pie_frame_controller.sv
// PIE frame sequencer: calibrates on delimiter/data-0/RTcal/TRcal, decodes bits, frames ~2*RTcal after last edge.
// Frame held stable on frame_valid until frame_ready; line ignored while held. PIE_GLITCH_FILTER_EN adds input filter.
module pie_frame_controller
  import pie_pkg::*;
#(
  parameter int CNT_W     = 7,
  parameter int DELIM_MIN = 2,
  parameter int DELIM_MAX = 5,
  parameter int RTCAL_MIN = 12,
  parameter int RTCAL_MAX = 20,
  parameter int TRCAL_MAX = 64,
  parameter int MAX_BITS  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_pie,
  input  logic                          frame_ready,
  output logic                          frame_valid,
  output logic [MAX_BITS-1:0]           frame_data,
  output logic [$clog2(MAX_BITS+1)-1:0] frame_len,
  output logic [CNT_W-1:0]              frame_rtcal,
  output logic [CNT_W-1:0]              frame_trcal,
  output logic                          trcal_present,
  output logic                          busy,
  output logic                          err,
  output logic [1:0]                    err_code
);

  localparam int LEN_W = $clog2(MAX_BITS+1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic rise, fall;

  pie_edge_sync u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .in_pie (in_pie),
    .rise   (rise),
    .fall   (fall)
  );

  pie_state_t state, state_nxt;

  logic [CNT_W-1:0]    cnt, rtcal_r, pivot_r, trcal_r;
  logic                trcal_pres_r;
  logic [MAX_BITS-1:0] shreg;
  logic [LEN_W-1:0]    bitcnt;
  logic [CNT_W:0]      two_rtcal;
  logic                timeout, bit_val;
  logic                start, lat_rtcal, lat_trcal, shift_en, done, err_set;
  logic [1:0]          err_cause;

  // Saturation doubles as the timeout when 2*rtcal is beyond the counter range
  assign two_rtcal = {rtcal_r, 1'b0};
  assign timeout   = ({1'b0, cnt} >= two_rtcal) || (cnt == CNT_MAX);
  assign bit_val   = cnt > pivot_r;
  assign busy      = (state != IDLE) && (state != HOLD);

  // Length counter: restarts on every rising edge, and on the delimiter's falling edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (rise || (state == IDLE && fall)) begin
      cnt <= CNT_W'(1);
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    lat_rtcal = 1'b0;
    lat_trcal = 1'b0;
    shift_en  = 1'b0;
    done      = 1'b0;
    err_set   = 1'b0;
    err_cause = ERR_DELIM;
    case (state)
      IDLE: if (fall) begin
        start     = 1'b1;
        state_nxt = DELIM;
      end
      DELIM: begin
        if (rise) begin
          if (cnt >= CNT_W'(DELIM_MIN) && cnt <= CNT_W'(DELIM_MAX)) begin
            state_nxt = DATA0;
          end else begin
            err_set = 1'b1; err_cause = ERR_DELIM; state_nxt = IDLE;
          end
        end else if (cnt > CNT_W'(DELIM_MAX)) begin
          err_set = 1'b1; err_cause = ERR_DELIM; state_nxt = IDLE;
        end
      end
      DATA0: if (rise) state_nxt = RTCAL;
      RTCAL: if (rise) begin
        if (cnt >= CNT_W'(RTCAL_MIN) && cnt <= CNT_W'(RTCAL_MAX)) begin
          lat_rtcal = 1'b1; state_nxt = FIRST;
        end else begin
          err_set = 1'b1; err_cause = ERR_RTCAL; state_nxt = IDLE;
        end
      end
      // Longer than RTcal here means TRcal; otherwise it is already the first data bit
      FIRST: begin
        if (rise) begin
          if (cnt > rtcal_r) begin
            if (cnt <= CNT_W'(TRCAL_MAX)) begin
              lat_trcal = 1'b1; state_nxt = DATA;
            end else begin
              err_set = 1'b1; err_cause = ERR_SYM; state_nxt = IDLE;
            end
          end else begin
            shift_en = 1'b1; state_nxt = DATA;
          end
        end else if (timeout) begin
          err_set = 1'b1; err_cause = ERR_SYM; state_nxt = IDLE;
        end
      end
      DATA: begin
        if (rise) begin
          if (cnt > rtcal_r) begin
            err_set = 1'b1; err_cause = ERR_SYM; state_nxt = IDLE;
          end else if (bitcnt == LEN_W'(MAX_BITS)) begin
            err_set = 1'b1; err_cause = ERR_OVF; state_nxt = IDLE;
          end else begin
            shift_en = 1'b1;
          end
        end else if (timeout) begin
          if (bitcnt == '0) begin
            err_set = 1'b1; err_cause = ERR_SYM; state_nxt = IDLE;
          end else begin
            done = 1'b1; state_nxt = HOLD;
          end
        end
      end
      HOLD: if (frame_valid && frame_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rtcal_r       <= '0;
      pivot_r       <= '0;
      trcal_r       <= '0;
      trcal_pres_r  <= 1'b0;
      shreg         <= '0;
      bitcnt        <= '0;
      err           <= 1'b0;
      err_code      <= 2'd0;
      frame_valid   <= 1'b0;
      frame_data    <= '0;
      frame_len     <= '0;
      frame_rtcal   <= '0;
      frame_trcal   <= '0;
      trcal_present <= 1'b0;
    end else begin
      if (start) begin
        trcal_r      <= '0;
        trcal_pres_r <= 1'b0;
        shreg        <= '0;
        bitcnt       <= '0;
      end
      if (lat_rtcal) begin
        rtcal_r <= cnt;
        pivot_r <= cnt >> 1;
      end
      if (lat_trcal) begin
        trcal_r      <= cnt;
        trcal_pres_r <= 1'b1;
      end
      if (shift_en) begin
        shreg  <= {shreg[MAX_BITS-2:0], bit_val};
        bitcnt <= bitcnt + LEN_W'(1);
      end
      err <= err_set;
      if (err_set) err_code <= err_cause;
      if (done) begin
        frame_valid   <= 1'b1;
        frame_data    <= shreg;
        frame_len     <= bitcnt;
        frame_rtcal   <= rtcal_r;
        frame_trcal   <= trcal_r;
        trcal_present <= trcal_pres_r;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pie_frame_controller.sv
// Scoreboard bench for pie_frame_controller: expected frames/errors queued at stimulus, compared on output.
module tb_pie_frame_controller;

  localparam int MAX_BITS = 32;
  localparam int CNT_W    = 7;
  localparam int LEN_W    = $clog2(MAX_BITS+1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_pie = 1'b1;
  logic              frame_ready = 1'b1;
  logic              frame_valid;
  logic [MAX_BITS-1:0] frame_data;
  logic [LEN_W-1:0]  frame_len;
  logic [CNT_W-1:0]  frame_rtcal;
  logic [CNT_W-1:0]  frame_trcal;
  logic              trcal_present;
  logic              busy;
  logic              err;
  logic [1:0]        err_code;

  pie_frame_controller #(.CNT_W(CNT_W), .MAX_BITS(MAX_BITS)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_pie        (in_pie),
    .frame_ready   (frame_ready),
    .frame_valid   (frame_valid),
    .frame_data    (frame_data),
    .frame_len     (frame_len),
    .frame_rtcal   (frame_rtcal),
    .frame_trcal   (frame_trcal),
    .trcal_present (trcal_present),
    .busy          (busy),
    .err           (err),
    .err_code      (err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              is_err;
    logic [1:0]        code;
    logic [MAX_BITS-1:0] data;
    logic [LEN_W-1:0]  len;
    logic [CNT_W-1:0]  rtcal;
    logic [CNT_W-1:0]  trcal;
    logic              tp;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   sym_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_line(input logic v, input int n);
    in_pie = v;
    repeat (n) tick();
  endtask

  // Delimiter low for delim_lo cycles, then each symbol as high (L-2) + low 2, then idle high
  task automatic send(input int delim_lo);
    hold_line(1'b0, delim_lo);
    foreach (sym_q[i]) begin
      hold_line(1'b1, sym_q[i] - 2);
      hold_line(1'b0, 2);
    end
    in_pie = 1'b1;
  endtask

  task automatic push_frame(input logic [31:0] d, input int len, input int rt, input int tr, input logic tp);
    exp_t e;
    e.is_err = 1'b0;
    e.code   = 2'd0;
    e.data   = d;
    e.len    = LEN_W'(len);
    e.rtcal  = CNT_W'(rt);
    e.trcal  = CNT_W'(tr);
    e.tp     = tp;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_t e;
    e        = '0;
    e.is_err = 1'b1;
    e.code   = code;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    repeat (40) tick();
  endtask

  always @(negedge clk) begin
    if (rst && (err || (frame_valid && frame_ready))) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'({err, frame_valid}), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("kind_is_err", 64'(err), 64'(mon_e.is_err));
        if (mon_e.is_err) begin
          check("err_code", 64'(err_code), 64'(mon_e.code));
        end else begin
          check("frame_data", 64'(frame_data), 64'(mon_e.data));
          check("frame_len", 64'(frame_len), 64'(mon_e.len));
          check("frame_rtcal", 64'(frame_rtcal), 64'(mon_e.rtcal));
          check("frame_trcal", 64'(frame_trcal), 64'(mon_e.trcal));
          check("trcal_present", 64'(trcal_present), 64'(mon_e.tp));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b0;
    repeat (3) tick();
    check("rst_frame_valid", 64'(frame_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);
    check("rst_frame_data", 64'(frame_data), 64'd0);
    check("rst_frame_len", 64'(frame_len), 64'd0);
    rst = 1'b1;
    repeat (5) tick();

    // Preamble with TRcal, bits 1,0,1,1
    sym_q = '{6, 16, 32, 10, 6, 10, 10};
    push_frame(32'hB, 4, 16, 32, 1'b1);
    send(3);
    wait_drain("preamble_done", 300);

    // Frame-sync, bits 0,1
    sym_q = '{6, 16, 6, 10};
    push_frame(32'h1, 2, 16, 0, 1'b0);
    send(3);
    wait_drain("framesync_done", 300);

    // Pivot boundary: 8 -> 0, 9 -> 1
    sym_q = '{6, 16, 8, 9, 6, 10};
    push_frame(32'h5, 4, 16, 0, 1'b0);
    send(3);
    wait_drain("pivot_done", 300);

    // RTcal at upper limit 20, pivot 10: 10 -> 0, 11 -> 1
    sym_q = '{6, 20, 10, 11};
    push_frame(32'h1, 2, 20, 0, 1'b0);
    send(3);
    wait_drain("rtcal_max_done", 300);

    // Delimiter too long
    sym_q.delete();
    push_err(2'd0);
    send(6);
    wait_drain("delim_err_done", 100);

    // RTcal out of range
    sym_q = '{6, 22};
    push_err(2'd1);
    send(3);
    wait_drain("rtcal_err_done", 100);

    // Overflow: 33 data symbols
    sym_q = '{6, 16};
    for (int i = 0; i < 33; i++) sym_q.push_back(6);
    push_err(2'd3);
    send(3);
    wait_drain("ovf_done", 100);

    // Backpressure: first frame held, second ignored
    frame_ready = 1'b0;
    sym_q = '{6, 16, 10, 10, 6};
    push_frame(32'h6, 3, 16, 0, 1'b0);
    send(3);
    n = 0;
    while (!frame_valid && n < 300) begin
      tick();
      n++;
    end
    check("bp_valid_up", 64'(frame_valid), 64'd1);
    sym_q = '{6, 16, 6, 6, 6, 10};
    send(3);
    repeat (40) tick();
    check("bp_valid_held", 64'(frame_valid), 64'd1);
    check("bp_data_held", 64'(frame_data), 64'h6);
    check("bp_len_held", 64'(frame_len), 64'd3);
    check("bp_busy_hold", 64'(busy), 64'd0);
    check("bp_not_consumed", 64'(exp_q.size()), 64'd1);
    frame_ready = 1'b1;
    tick();
    check("bp_valid_drop", 64'(frame_valid), 64'd0);
    check("bp_busy_after", 64'(busy), 64'd0);
    repeat (20) tick();
    check("bp_busy_idle", 64'(busy), 64'd0);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Async reset in the middle of DATA
    sym_q = '{6, 16, 10, 6};
    send(3);
    repeat (8) tick();
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check("arst_frame_valid", 64'(frame_valid), 64'd0);
    check("arst_frame_data", 64'(frame_data), 64'd0);
    check("arst_frame_len", 64'(frame_len), 64'd0);
    check("arst_frame_rtcal", 64'(frame_rtcal), 64'd0);
    check("arst_err_code", 64'(err_code), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_err", 64'(err), 64'd0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (5) tick();

    // Decode after reset: TRcal 24, bits 0,1,1
    sym_q = '{6, 16, 24, 6, 10, 10};
    push_frame(32'h3, 3, 16, 24, 1'b1);
    send(3);
    wait_drain("post_reset_done", 300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pie_frame_controller.md
Name: pie_frame_controller

Overview:
Forward-link PIE frame sequencer. It locks onto the delimiter, data-0, RTcal and optional TRcal preamble on the raw PIE line, and derives the bit pivot from the measured RTcal. It then classifies each data symbol, assembles the command frame and hands it to the command parser over a valid/ready handshake. It sits between the RX front-end comparator and the command layer, and replaces fixed-period decoding with per-frame calibration.

Parameters:
- CNT_W, 7, symbol counter width; the counter saturates at 2^CNT_W-1.
- DELIM_MIN, 2, minimum delimiter low time in cycles.
- DELIM_MAX, 5, maximum delimiter low time in cycles.
- RTCAL_MIN, 12, minimum legal RTcal in cycles.
- RTCAL_MAX, 20, maximum legal RTcal in cycles.
- TRCAL_MAX, 64, maximum legal TRcal in cycles.
- MAX_BITS, 32, frame buffer depth in bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- in_pie  in  1  raw PIE line; idle high; asynchronous to clk.
- frame_ready  in  1  consumer accepts the frame.
- frame_valid  out  1  frame available.
- frame_data  out  MAX_BITS  received bits; first bit in the MSB of the used field; right-justified.
- frame_len  out  $clog2(MAX_BITS+1)  number of valid bits.
- frame_rtcal  out  CNT_W  measured RTcal.
- frame_trcal  out  CNT_W  measured TRcal; 0 if absent.
- trcal_present  out  1  preamble (with TRcal) rather than frame-sync.
- busy  out  1  high in every state except IDLE and HOLD.
- err  out  1  one-cycle error pulse.
- err_code  out  2  error cause: 0 delimiter, 1 RTcal, 2 symbol/TRcal, 3 overflow; held until the next err.

Behaviour:
- Reset: all outputs 0 and state IDLE; the synchronizer flops reset to 1 (idle line).
- in_pie passes through a 2-flop synchronizer. Edges are detected on the synchronized signal, which adds 3 cycles of fixed latency; all lengths are counted on the synchronized signal.
- Symbols are measured rising edge to rising edge. The counter resets to 1 on the edge and increments every cycle, saturating.
- IDLE: on a falling edge, go to DELIM.
- DELIM: on a rising edge, check the low length against [DELIM_MIN, DELIM_MAX].
  - In range: go to DATA0.
  - Out of range: err, code 0, go to IDLE.
  - If the length exceeds DELIM_MAX before the edge arrives, err immediately.
- DATA0: the next rising edge ends data-0, which is accepted with no range check. Go to RTCAL.
- RTCAL: on the rising edge, check the length against [RTCAL_MIN, RTCAL_MAX].
  - In range: latch rtcal and pivot = rtcal>>1, go to FIRST.
  - Out of range: err, code 1, go to IDLE.
- FIRST: on the rising edge, compare len with rtcal.
  - len > rtcal and len <= TRCAL_MAX: latch trcal, set trcal_present, go to DATA.
  - len > TRCAL_MAX: err, code 2.
  - len <= rtcal: this symbol is the first data bit; go to DATA.
- DATA: on each rising edge, bit = (len > pivot), so len == pivot decodes as 0. Shift left with the new bit at the LSB and increment the bit count.
  - len > rtcal: err, code 2.
  - Bit count would exceed MAX_BITS: err, code 3.
  - Any error returns to IDLE.
- End of frame: in FIRST or DATA, if the count since the last rising edge reaches 2*rtcal with no edge, the frame ends.
  - Bit count = 0: err, code 2, go to IDLE.
  - Otherwise: register the outputs, assert frame_valid, go to HOLD.
- HOLD: frame_valid and all frame_* outputs are stable. Line activity is ignored.
  - On frame_valid & frame_ready: deassert frame_valid next cycle, return to IDLE.
  - frame_ready asserted while frame_valid is low has no effect.
- Errors do not alter the frame_* outputs of a previously delivered frame.
- A falling edge while in DATA0, RTCAL, FIRST or DATA is part of a symbol (low PW), not a new delimiter.
- Async reset mid-frame: immediate return to IDLE; a partial frame is discarded with no err.
- Arithmetic: 2*rtcal is computed at CNT_W+1 bits. With the saturating counter, a timeout beyond 2^CNT_W-1 is reached at saturation.

Optional Feature:
PIE_GLITCH_FILTER_EN.
- Defined: a 3-sample majority filter follows the synchronizer; the line changes only after 2 of 3 agreeing samples. This adds 1 cycle of latency, and pulses of 1 cycle are rejected.
- Undefined: the synchronizer output is used directly.

Decomposition:
- Package pie_pkg holds:
  - the state enum (IDLE, DELIM, DATA0, RTCAL, FIRST, DATA, HOLD);
  - the err_code localparams (ERR_DELIM, ERR_RTCAL, ERR_SYM, ERR_OVF).
- One sub-module, pie_edge_sync: synchronizer, optional glitch filter, and rise/fall pulse outputs.

Test Plan:
- Preamble: delimiter low 3, data-0 6, RTcal 16, TRcal 32, bits 1,0,1,1 (10,6,10,10 cycles, 2-cycle low PW each), then line high. Expect frame_valid with len=4, data=...1011, rtcal=16, trcal=32, trcal_present=1.
- Frame-sync: the same sequence without TRcal, bits 0,1. Expect len=2, data=...01, trcal=0, trcal_present=0.
- Boundaries:
  - Delimiter low 6: err, code 0, no frame.
  - RTcal 22: err, code 1.
  - Data symbol exactly 8 (pivot) with RTcal 16: decodes as 0.
- Overflow: 33 data symbols with MAX_BITS=32. Expect err, code 3 on the 33rd symbol and no frame_valid.
- Backpressure: hold frame_ready=0 for 50 cycles and send a second full frame meanwhile. Expect the first frame held unchanged and the second frame ignored. Then assert ready: valid drops the next cycle and busy stays 0.
- Reset: drive rst low in the middle of DATA. Expect all outputs 0 immediately, no err, and a correct decode of the next frame.
